module_lcd_ctrl: RTL and testbench



---
 rtl/mini_cpu_pkg.sv | 54 +++++
 rtl/module_bin2bcd.sv | 49 ++++
 rtl/module_lcd_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_module_lcd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared mini-CPU definitions: opcodes, HD44780 command bytes, LCD controller
// state encodings and the opcode mnemonic table used by the display stage.
package mini_cpu_pkg;

   localparam logic [2:0] OP_LOAD    = 3'd0;
   localparam logic [2:0] OP_ADD     = 3'd1;
   localparam logic [2:0] OP_ADDI    = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_SUBI    = 3'd4;
   localparam logic [2:0] OP_MUL     = 3'd5;
   localparam logic [2:0] OP_CLEAR   = 3'd6;
   localparam logic [2:0] OP_DISPLAY = 3'd7;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_LINE1    = 8'h80;
   localparam logic [7:0] LCD_LINE2    = 8'hC0;

   localparam int unsigned INIT_BYTES  = 4;
   localparam int unsigned FRAME_BYTES = 34;

   typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_CONV, ST_WRITE} lcd_state_t;
   typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} lcd_phase_t;

   function automatic logic [7:0] init_cmd(input logic [5:0] i);
      case (i)
         6'd0:    return LCD_FUNC_SET;
         6'd1:    return LCD_DISP_ON;
         6'd2:    return LCD_CLEAR;
         default: return LCD_ENTRY;
      endcase
   endfunction

   // Character at column pos of the space-padded 16-column mnemonic field.
   function automatic logic [7:0] mnemonic_char(input logic [2:0] op, input logic [3:0] pos);
      logic [63:0] s;
      logic [63:0] t;
      case (op)
         OP_LOAD:    s = "LOAD    ";
         OP_ADD:     s = "ADD     ";
         OP_ADDI:    s = "ADDI    ";
         OP_SUB:     s = "SUB     ";
         OP_SUBI:    s = "SUBI    ";
         OP_MUL:     s = "MUL     ";
         OP_CLEAR:   s = "CLEAR   ";
         default:    s = "DISPLAY ";
      endcase
      t = s << {pos[2:0], 3'b000};
      return pos[3] ? 8'h20 : t[63:56];
   endfunction

endpackage

// File: rtl/module_bin2bcd.sv
// Sequential double-dabble: 16-bit binary to five BCD digits in 16 shift
// cycles; done pulses for one cycle and bcd holds until the next start.
module module_bin2bcd (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [15:0]     bin,
   output logic            done,
   output logic [4:0][3:0] bcd
);

   logic [35:0] sh;
   logic [35:0] adj;
   logic [3:0]  cnt;
   logic        run;

   always_comb begin
      adj = sh;
      for (int unsigned i = 0; i < 5; i++) begin
         if (adj[16+4*i +: 4] >= 4'd5) adj[16+4*i +: 4] = adj[16+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh   <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         sh   <= {20'd0, bin};
         cnt  <= '0;
         run  <= 1'b1;
         done <= 1'b0;
      end else if (run) begin
         sh  <= {adj[34:0], 1'b0};
         cnt <= cnt + 4'd1;
         if (cnt == 4'd15) begin
            run  <= 1'b0;
            done <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

   assign bcd = sh[35:16];

endmodule

// File: rtl/module_lcd_ctrl.sv
// HD44780 16x2 display stage: power-up wait, init commands, then a 34-byte
// frame (mnemonic line + signed decimal result line) per CPU update strobe.
module module_lcd_ctrl
   import mini_cpu_pkg::*;
#(
   parameter int unsigned T_PWRUP = 750_000,
   parameter int unsigned T_EN    = 25,
   parameter int unsigned T_CMD   = 2_000,
   parameter int unsigned T_CLR   = 82_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        update,
   input  logic [2:0]  opcode,
   input  logic [15:0] result,
   output logic        busy,
   output logic [7:0]  lcd_data,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_en
);

   lcd_state_t     state, state_d;
   lcd_phase_t     ph, ph_d;
   logic [31:0]    timer, timer_d, wait_len;
   logic [5:0]     idx, idx_d, n, j;
   logic [7:0]     data_d, seq_data;
   logic           rs_d, en_d, busy_d, seq_rs, go_conv, last_byte;
   logic           pending, frm_neg, bcd_done;
   logic [2:0]     op_q, frm_op, src_op;
   logic [15:0]    res_q, src_res, mag;
   logic [4:0][3:0] bcd;

   assign lcd_rw    = 1'b0;
   assign src_op    = update ? opcode : op_q;
   assign src_res   = update ? result : res_q;
   assign mag       = src_res[15] ? (~src_res + 16'd1) : src_res;
   assign wait_len  = (!lcd_rs && lcd_data == LCD_CLEAR) ? T_CLR : T_CMD;
   assign last_byte = (state == ST_INIT) ? (idx == 6'(INIT_BYTES - 1)) : (idx == 6'(FRAME_BYTES - 1));

   module_bin2bcd u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (go_conv),
      .bin   (mag),
      .done  (bcd_done),
      .bcd   (bcd)
   );

   // Byte that follows the current one in the init or frame sequence.
   always_comb begin
      n        = idx + 6'd1;
      j        = n - 6'd18;
      seq_rs   = 1'b0;
      seq_data = 8'h20;
      if (state == ST_INIT) begin
         seq_data = init_cmd(n);
      end else if (n <= 6'd16) begin
         seq_rs   = 1'b1;
         seq_data = mnemonic_char(frm_op, 4'(n - 6'd1));
      end else if (n == 6'd17) begin
         seq_data = LCD_LINE2;
      end else begin
         seq_rs = 1'b1;
         case (j)
            6'd0:    seq_data = "R";
            6'd1:    seq_data = "=";
            6'd2:    seq_data = frm_neg ? "-" : " ";
            6'd3:    seq_data = {4'h3, bcd[4]};
            6'd4:    seq_data = {4'h3, bcd[3]};
            6'd5:    seq_data = {4'h3, bcd[2]};
            6'd6:    seq_data = {4'h3, bcd[1]};
            6'd7:    seq_data = {4'h3, bcd[0]};
            default: seq_data = 8'h20;
         endcase
      end
   end

   always_comb begin
      state_d = state;
      ph_d    = ph;
      timer_d = timer + 32'd1;
      idx_d   = idx;
      data_d  = lcd_data;
      rs_d    = lcd_rs;
      en_d    = 1'b0;
      go_conv = 1'b0;
      case (state)
         ST_PWRUP: begin
            if (timer == T_PWRUP - 1) begin
               state_d = ST_INIT;
               ph_d    = PH_SETUP;
               idx_d   = '0;
               timer_d = '0;
               rs_d    = 1'b0;
               data_d  = LCD_FUNC_SET;
            end
         end
         ST_INIT, ST_WRITE: begin
            case (ph)
               PH_SETUP: begin
                  ph_d    = PH_EN;
                  timer_d = '0;
                  en_d    = 1'b1;
               end
               PH_EN: begin
                  if (timer == T_EN - 1) begin
                     ph_d    = PH_WAIT;
                     timer_d = '0;
                  end else begin
                     en_d = 1'b1;
                  end
               end
               default: begin
                  if (timer == wait_len - 32'd1) begin
                     timer_d = '0;
                     if (!last_byte) begin
                        idx_d  = idx + 6'd1;
                        ph_d   = PH_SETUP;
                        rs_d   = seq_rs;
                        data_d = seq_data;
                     end else if (pending || update) begin
                        // Skip the IDLE cycle so busy never drops between frames.
                        go_conv = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end
               end
            endcase
         end
         ST_IDLE: begin
            timer_d = '0;
            if (update) go_conv = 1'b1;
         end
         ST_CONV: begin
            timer_d = '0;
            if (bcd_done) begin
               state_d = ST_WRITE;
               ph_d    = PH_SETUP;
               idx_d   = '0;
               rs_d    = 1'b0;
               data_d  = LCD_LINE1;
            end
         end
         default: state_d = ST_PWRUP;
      endcase
      if (go_conv) state_d = ST_CONV;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_PWRUP;
         ph       <= PH_SETUP;
         timer    <= '0;
         idx      <= '0;
         lcd_data <= '0;
         lcd_rs   <= 1'b0;
         lcd_en   <= 1'b0;
         busy     <= 1'b1;
      end else begin
         state    <= state_d;
         ph       <= ph_d;
         timer    <= timer_d;
         idx      <= idx_d;
         lcd_data <= data_d;
         lcd_rs   <= rs_d;
         lcd_en   <= en_d;
         busy     <= busy_d;
      end
   end

   // Latest strobe always wins; the frame copy is frozen when conversion starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         op_q    <= '0;
         res_q   <= '0;
         frm_op  <= '0;
         frm_neg <= 1'b0;
      end else begin
         if (update) begin
            op_q  <= opcode;
            res_q <= result;
         end
         if (go_conv) begin
            pending <= 1'b0;
            frm_op  <= src_op;
            frm_neg <= src_res[15];
         end else if (update) begin
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_module_lcd_ctrl.sv
// Bench for module_lcd_ctrl: expected LCD byte stream built from the display
// rules, checked by a bus monitor every cycle, plus directed literal checks.
module tb_module_lcd_ctrl;

   localparam int unsigned T_PWRUP = 50;
   localparam int unsigned T_EN    = 2;
   localparam int unsigned T_CMD   = 5;
   localparam int unsigned T_CLR   = 20;
   localparam int          L_STD   = 1 + T_EN + T_CMD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        update;
   logic [2:0]  opcode;
   logic [15:0] result;
   logic        busy, lcd_rs, lcd_rw, lcd_en;
   logic [7:0]  lcd_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         gap;
   } ebyte_t;

   ebyte_t     expq[$];
   logic [8:0] cap[$];
   string      mn[8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DISPLAY"};

   module_lcd_ctrl #(
      .T_PWRUP (T_PWRUP),
      .T_EN    (T_EN),
      .T_CMD   (T_CMD),
      .T_CLR   (T_CLR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .update   (update),
      .opcode   (opcode),
      .result   (result),
      .busy     (busy),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_en   (lcd_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   function automatic void push_byte(input logic rs, input logic [7:0] d, input int gap);
      ebyte_t e;
      e.rs  = rs;
      e.d   = d;
      e.gap = gap;
      expq.push_back(e);
   endfunction

   function automatic void push_init();
      push_byte(1'b0, 8'h38, 0);
      push_byte(1'b0, 8'h0C, L_STD);
      push_byte(1'b0, 8'h01, L_STD);
      push_byte(1'b0, 8'h06, 1 + T_EN + T_CLR);
   endfunction

   function automatic void push_frame(input logic [2:0] op, input logic [15:0] res, input int gap0);
      int mag;
      int div;
      push_byte(1'b0, 8'h80, gap0);
      for (int i = 0; i < 16; i++)
         push_byte(1'b1, (i < mn[op].len()) ? mn[op][i] : 8'h20, L_STD);
      push_byte(1'b0, 8'hC0, L_STD);
      mag = res[15] ? 65536 - int'(res) : int'(res);
      push_byte(1'b1, "R", L_STD);
      push_byte(1'b1, "=", L_STD);
      push_byte(1'b1, res[15] ? "-" : " ", L_STD);
      div = 10000;
      for (int i = 0; i < 5; i++) begin
         push_byte(1'b1, 8'(48 + (mag / div) % 10), L_STD);
         div = div / 10;
      end
      for (int i = 0; i < 8; i++) push_byte(1'b1, 8'h20, L_STD);
   endfunction

   function automatic string line_of(input int base);
      string s = "";
      if (cap.size() < base + 16) return "<short>";
      for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, cap[base+i][7:0]);
      return s;
   endfunction

   // Bus monitor: byte order/content, EN width, inter-byte spacing, data stability.
   int         cyc = 0;
   int         last_rise, last_chg, nchg, en_cnt;
   logic       prev_en;
   logic [8:0] prev_bus;

   always @(negedge clk) begin
      logic [8:0] bus;
      logic       chg;
      ebyte_t     e;
      cyc++;
      bus = {lcd_rs, lcd_data};
      if (!rst_n) begin
         prev_en  = 1'b0;
         prev_bus = '0;
         nchg     = 0;
         en_cnt   = 0;
      end else begin
         chk("lcd_rw", 32'(lcd_rw), 32'd0);
         chg = (bus != prev_bus);
         if (lcd_en && !prev_en) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got 0x%0h expected none", bus);
            end else begin
               e = expq.pop_front();
               chk("byte", 32'(bus), 32'({e.rs, e.d}));
               if (e.gap != 0) chk("byte_gap", 32'(cyc - last_rise), 32'(e.gap));
            end
            chk("setup_stable", 32'(!chg && (nchg == 0 || (nchg == 1 && last_chg == cyc - 1))), 32'd1);
            cap.push_back(bus);
            last_rise = cyc;
            nchg      = 0;
            en_cnt    = 0;
         end
         if (lcd_en) en_cnt++;
         if (!lcd_en && prev_en) chk("en_width", 32'(en_cnt), T_EN);
         if (chg) begin
            nchg++;
            last_chg = cyc;
         end
         prev_en  = lcd_en;
         prev_bus = bus;
      end
   end

   task automatic release_and_init(input string tag);
      cap.delete();
      push_init();
      @(negedge clk) rst_n = 1'b1;
      repeat (96) @(posedge clk);
      #1 chk({tag, "_busy_before_idle"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1 chk({tag, "_busy_idle_at_97"}, 32'(busy), 32'd0);
      chk({tag, "_init_count"}, 32'(cap.size()), 32'd4);
      chk({tag, "_init_pending"}, 32'(expq.size()), 32'd0);
      if (cap.size() > 2) begin
         chk({tag, "_first_cmd"}, 32'(cap[0]), 32'h038);
         chk({tag, "_clear_cmd"}, 32'(cap[2]), 32'h001);
      end
   endtask

   task automatic do_frame(input logic [2:0] op, input logic [15:0] res, input logic [7:0] prev,
                           input string l1, input string l2);
      cap.delete();
      push_frame(op, res, 0);
      @(negedge clk);
      update = 1'b1;
      opcode = op;
      result = res;
      @(posedge clk);
      #1 update = 1'b0;
      repeat (16) @(posedge clk);
      #1 chk("lat_prev_data", 32'(lcd_data), 32'(prev));
      chk("lat_prev_en", 32'(lcd_en), 32'd0);
      @(posedge clk);
      #1 chk("lat_setup_data", 32'(lcd_data), 32'h80);
      chk("lat_setup_en", 32'(lcd_en), 32'd0);
      chk("lat_setup_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1 chk("lat_en_high", 32'(lcd_en), 32'd1);
      repeat (270) @(posedge clk);
      #1 chk("frame_busy_last", 32'(busy), 32'd1);
      @(posedge clk);
      #1 chk("frame_busy_fall", 32'(busy), 32'd0);
      chk("frame_bytes", 32'(cap.size()), 32'd34);
      chk("frame_pending", 32'(expq.size()), 32'd0);
      if (cap.size() > 17) chk("line2_cmd", 32'(cap[17]), 32'h0C0);
      chk_str("line1", line_of(1), l1);
      chk_str("line2", line_of(18), l2);
   endtask

   // Frame A strobed at edge N; X (optional) and B strobed at edges N+kx, N+kb.
   task automatic two_frames(input logic [2:0] opa, input logic [15:0] resa,
                             input int kx, input logic [2:0] opx, input logic [15:0] resx,
                             input int kb, input logic [2:0] opb, input logic [15:0] resb,
                             input string l1, input string l2);
      int fall = -1;
      cap.delete();
      push_frame(opa, resa, 0);
      push_frame(opb, resb, L_STD + 17);
      @(negedge clk);
      update = 1'b1;
      opcode = opa;
      result = resa;
      @(posedge clk);
      #1 update = 1'b0;
      for (int k = 1; k <= 900; k++) begin
         @(posedge clk);
         #1;
         update = 1'b0;
         if (k + 1 == kx) begin
            update = 1'b1;
            opcode = opx;
            result = resx;
         end
         if (k + 1 == kb) begin
            update = 1'b1;
            opcode = opb;
            result = resb;
         end
         if (!busy) begin
            fall = k;
            break;
         end
      end
      update = 1'b0;
      chk("pair_busy_fall", 32'(fall), 32'd578);
      chk("pair_bytes", 32'(cap.size()), 32'd68);
      chk("pair_pending", 32'(expq.size()), 32'd0);
      chk_str("pair_line1", line_of(35), l1);
      chk_str("pair_line2", line_of(52), l2);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n  = 1'b1;
      update = 1'b0;
      opcode = '0;
      result = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data", 32'(lcd_data), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_rw", 32'(lcd_rw), 32'd0);
      chk("rst_en", 32'(lcd_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      release_and_init("init");

      do_frame(3'd1, 16'h0007, 8'h06, "ADD             ", "R= 00007        ");
      do_frame(3'd3, 16'h8000, 8'h20, "SUB             ", "R=-32768        ");
      do_frame(3'd6, 16'hFFFF, 8'h20, "CLEAR           ", "R=-00001        ");
      do_frame(3'd7, 16'h7FFF, 8'h20, "DISPLAY         ", "R= 32767        ");
      do_frame(3'd0, 16'h0000, 8'h20, "LOAD            ", "R= 00000        ");

      // Two mid-frame strobes: only the last one is shown, busy held throughout.
      two_frames(3'd0, 16'd100, 60, 3'd5, 16'd3, 66, 3'd2, 16'd9,
                 "ADDI            ", "R= 00009        ");
      // Strobe sampled on the very edge that ends the frame's last wait.
      two_frames(3'd5, 16'd16, 0, 3'd0, 16'd0, 289, 3'd4, 16'hFFF6,
                 "SUBI            ", "R=-00010        ");

      // Reset asserted while byte 10 of a frame is on the bus.
      cap.delete();
      push_frame(3'd6, 16'd5, 0);
      @(negedge clk);
      update = 1'b1;
      opcode = 3'd6;
      result = 16'd5;
      @(posedge clk);
      #1 update = 1'b0;
      for (int k = 0; k < 400 && cap.size() < 11; k++) @(negedge clk);
      chk("midrst_reached_byte10", 32'(cap.size()), 32'd11);
      chk("midrst_en_before", 32'(lcd_en), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_en", 32'(lcd_en), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_data", 32'(lcd_data), 32'd0);
      expq.delete();
      repeat (3) @(posedge clk);
      release_and_init("reinit");

      chk("final_pending", 32'(expq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
